// File: rtl/bn_compute_stage.sv
// Batch-normalization compute stage: pops samples from the BN FIFO register
// stage and streams y = gamma*(x - mean)*inv_std + beta with saturation.
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_IDLE | may issue a pop this cycle when enabled, not empty, not stalled
// ST_WAIT | post-pop guard cycle; the stale empty flag cannot double-pop
module bn_compute_stage #(
   parameter int DATA_WIDTH = 16,
   parameter int FRAC_BITS  = 8,
   parameter int READ_LAT   = 2
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         bn_en,
   input  logic                         bn_fifo_empty,
   input  logic                         bn_fifo_full,
   input  logic                         out_stall,
   input  logic signed [DATA_WIDTH-1:0] data_in,
   input  logic signed [DATA_WIDTH-1:0] bn_mean,
   input  logic signed [DATA_WIDTH-1:0] bn_inv_std,
   input  logic signed [DATA_WIDTH-1:0] bn_gamma,
   input  logic signed [DATA_WIDTH-1:0] bn_beta,
   output logic                         rd_en,
   output logic signed [DATA_WIDTH-1:0] data_out,
   output logic                         data_valid,
   output logic                         sat_flag,
   output logic                         full_seen,
   output logic                         busy,
   output logic [15:0]                  sample_count
);

   localparam int DW1 = DATA_WIDTH + 1;
   localparam int P2W = DW1 + DATA_WIDTH;
   localparam int P3W = 2 * DATA_WIDTH;
   localparam int Y3W = P3W + 1;
   localparam logic [DATA_WIDTH-1:0] SAT_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
   localparam logic [DATA_WIDTH-1:0] SAT_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

   typedef enum logic {ST_IDLE, ST_WAIT} state_t;

   state_t state, state_nxt;
   logic [READ_LAT-1:0] inflight;
   logic in_valid;

   logic                         s1_v;
   logic signed [DW1-1:0]        s1_diff;
   logic signed [DATA_WIDTH-1:0] s1_inv, s1_gamma, s1_beta;

   logic                         s2_v, s2_sat;
   logic signed [DATA_WIDTH-1:0] s2_n, s2_gamma, s2_beta;

   logic signed [P2W-1:0]        prod2, n2;
   logic                         ovf2;
   logic signed [DATA_WIDTH-1:0] n2_sat;

   logic signed [P3W-1:0]        prod3, scaled3;
   logic signed [Y3W-1:0]        sum3;
   logic                         ovf3;
   logic signed [DATA_WIDTH-1:0] y3_sat;

   // State register for the read FSM.
   always_ff @(posedge clk) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_nxt;
   end

   // Read decision; rd_en is held low while rst is asserted so no pop leaks out of reset.
   always_comb begin
      state_nxt = state;
      rd_en     = 1'b0;
      case (state)
         ST_IDLE: begin
            if (!rst && bn_en && !bn_fifo_empty && !out_stall) begin
               rd_en     = 1'b1;
               state_nxt = ST_WAIT;
            end
         end
         ST_WAIT: state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Tracks issued pops until their data arrives on data_in.
   always_ff @(posedge clk) begin
      if (rst) begin
         inflight <= '0;
      end else begin
         inflight[0] <= rd_en;
         for (int i = 1; i < READ_LAT; i++) inflight[i] <= inflight[i-1];
      end
   end

   assign in_valid = inflight[READ_LAT-1];

   // S1: centre the sample and carry the remaining parameters forward.
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_v     <= 1'b0;
         s1_diff  <= '0;
         s1_inv   <= '0;
         s1_gamma <= '0;
         s1_beta  <= '0;
      end else begin
         s1_v <= in_valid;
         if (in_valid) begin
            s1_diff  <= DW1'(data_in) - DW1'(bn_mean);
            s1_inv   <= bn_inv_std;
            s1_gamma <= bn_gamma;
            s1_beta  <= bn_beta;
         end
      end
   end

   // S2 arithmetic: scale by inv_std, floor-shift, clamp to the data width.
   always_comb begin
      prod2  = P2W'(s1_diff) * P2W'(s1_inv);
      n2     = prod2 >>> FRAC_BITS;
      ovf2   = !((&n2[P2W-1:DATA_WIDTH-1]) || !(|n2[P2W-1:DATA_WIDTH-1]));
      n2_sat = ovf2 ? (n2[P2W-1] ? SAT_MIN : SAT_MAX) : n2[DATA_WIDTH-1:0];
   end

   // S2 register.
   always_ff @(posedge clk) begin
      if (rst) begin
         s2_v     <= 1'b0;
         s2_sat   <= 1'b0;
         s2_n     <= '0;
         s2_gamma <= '0;
         s2_beta  <= '0;
      end else begin
         s2_v <= s1_v;
         if (s1_v) begin
            s2_sat   <= ovf2;
            s2_n     <= n2_sat;
            s2_gamma <= s1_gamma;
            s2_beta  <= s1_beta;
         end
      end
   end

   // S3 arithmetic: apply gamma, add beta at full width, then clamp.
   always_comb begin
      prod3   = P3W'(s2_n) * P3W'(s2_gamma);
      scaled3 = prod3 >>> FRAC_BITS;
      sum3    = Y3W'(scaled3) + Y3W'(s2_beta);
      ovf3    = !((&sum3[Y3W-1:DATA_WIDTH-1]) || !(|sum3[Y3W-1:DATA_WIDTH-1]));
      y3_sat  = ovf3 ? (sum3[Y3W-1] ? SAT_MIN : SAT_MAX) : sum3[DATA_WIDTH-1:0];
   end

   // Output register; data_out and sat_flag hold between valid samples.
   always_ff @(posedge clk) begin
      if (rst) begin
         data_valid <= 1'b0;
         data_out   <= '0;
         sat_flag   <= 1'b0;
      end else begin
         data_valid <= s2_v;
         if (s2_v) begin
            data_out <= y3_sat;
            sat_flag <= s2_sat | ovf3;
         end
      end
   end

   // Emitted-sample counter and sticky FIFO-full status.
   always_ff @(posedge clk) begin
      if (rst) begin
         sample_count <= '0;
         full_seen    <= 1'b0;
      end else begin
         if (data_valid)   sample_count <= sample_count + 16'd1;
         if (bn_fifo_full) full_seen    <= 1'b1;
      end
   end

   assign busy = (state != ST_IDLE) || (|inflight) || s1_v || s2_v;

endmodule

// File: tb/tb_bn_compute_stage.sv
// Randomized and directed bench for bn_compute_stage against an arithmetic reference.
module tb_bn_compute_stage;

   logic clk = 1'b0;
   logic rst, bn_en, bn_fifo_empty, bn_fifo_full, out_stall;
   logic signed [15:0] data_in, bn_mean, bn_inv_std, bn_gamma, bn_beta;
   logic rd_en, data_valid, sat_flag, full_seen, busy;
   logic signed [15:0] data_out;
   logic [15:0] sample_count;

   bn_compute_stage #(.DATA_WIDTH(16), .FRAC_BITS(8), .READ_LAT(2)) dut (
      .clk(clk), .rst(rst), .bn_en(bn_en), .bn_fifo_empty(bn_fifo_empty),
      .bn_fifo_full(bn_fifo_full), .out_stall(out_stall), .data_in(data_in),
      .bn_mean(bn_mean), .bn_inv_std(bn_inv_std), .bn_gamma(bn_gamma), .bn_beta(bn_beta),
      .rd_en(rd_en), .data_out(data_out), .data_valid(data_valid), .sat_flag(sat_flag),
      .full_seen(full_seen), .busy(busy), .sample_count(sample_count)
   );

   always #5 clk = ~clk;

   typedef struct {int x; int mean; int inv; int g; int b;} smp_t;

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;

   // reference state: pop history (index k = k cycles ago) and input history
   bit   rd_h[1:5];
   smp_t in_h[1:3];
   int   dout_x;
   bit [15:0] cnt_x;
   bit   fs_x;

   // observation bookkeeping for directed windows
   int rd_pulses, valid_seen, last_rd_cyc, last_valid_cyc, last_dout;
   bit last_sat;

   int drv_x, drv_mean, drv_inv, drv_g, drv_b;

   task automatic check(input string tag, input longint got, input longint exp);
      n_checks++;
      if (got != exp) begin
         n_errors++;
         $display("FAIL %s @cyc %0d: got %0d expected %0d", tag, cyc, got, exp);
      end
   endtask

   function automatic longint floor_div256(input longint a);
      if (a >= 0) return a / 256;
      return -((-a + 255) / 256);
   endfunction

   function automatic longint clamp16(input longint a, inout bit sat);
      if (a > 32767)  begin sat = 1'b1; return 32767;  end
      if (a < -32768) begin sat = 1'b1; return -32768; end
      return a;
   endfunction

   function automatic void bn_ref(input smp_t s, output int y, output bit sat);
      longint n, m;
      sat = 1'b0;
      n = clamp16(floor_div256(longint'(s.x - s.mean) * s.inv), sat);
      m = clamp16(floor_div256(n * s.g) + s.b, sat);
      y = int'(m);
   endfunction

   function automatic int rnd16();
      case ($urandom_range(0, 7))
         0:       return 32767;
         1:       return -32768;
         2:       return int'($urandom_range(0, 1023)) - 512;
         default: return int'($signed(16'($urandom)));
      endcase
   endfunction

   task automatic rand_data();
      drv_x = rnd16(); drv_mean = rnd16(); drv_inv = rnd16(); drv_g = rnd16(); drv_b = rnd16();
   endtask

   task automatic set_data(input int x, mean, inv, g, b);
      drv_x = x; drv_mean = mean; drv_inv = inv; drv_g = g; drv_b = b;
   endtask

   // One clock cycle: drive, predict, sample at negedge, compare, advance model.
   task automatic step(input bit r, en, emp, stl, fl);
      bit rd_x, dv_x, busy_x, s;
      int y;
      rst = r; bn_en = en; bn_fifo_empty = emp; out_stall = stl; bn_fifo_full = fl;
      data_in = 16'(drv_x); bn_mean = 16'(drv_mean); bn_inv_std = 16'(drv_inv);
      bn_gamma = 16'(drv_g); bn_beta = 16'(drv_b);
      rd_x   = !r && en && !emp && !stl && !rd_h[1];
      dv_x   = rd_h[5];
      busy_x = rd_h[1] || rd_h[2] || rd_h[3] || rd_h[4];
      bn_ref(in_h[3], y, s);
      @(negedge clk);
      check("rd_en", rd_en, rd_x);
      if (rd_en) begin rd_pulses++; last_rd_cyc = cyc; end
      if (!r) begin
         check("data_valid", data_valid, dv_x);
         if (dv_x) begin
            check("data_out", data_out, y);
            check("sat_flag", sat_flag, s);
         end else begin
            check("data_out_hold", data_out, dout_x);
         end
         check("sample_count", sample_count, cnt_x);
         check("full_seen", full_seen, fs_x);
         check("busy", busy, busy_x);
         if (data_valid) begin
            valid_seen++; last_valid_cyc = cyc; last_dout = data_out; last_sat = sat_flag;
         end
      end
      if (r) begin
         for (int k = 1; k <= 5; k++) rd_h[k] = 1'b0;
         dout_x = 0; cnt_x = 16'd0; fs_x = 1'b0;
      end else begin
         if (dv_x) begin dout_x = y; cnt_x = cnt_x + 16'd1; end
         if (fl) fs_x = 1'b1;
         for (int k = 5; k > 1; k--) rd_h[k] = rd_h[k-1];
         rd_h[1] = rd_x;
      end
      in_h[3] = in_h[2]; in_h[2] = in_h[1];
      in_h[1] = '{drv_x, drv_mean, drv_inv, drv_g, drv_b};
      @(posedge clk); #1;
      cyc++;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 1, 1, 0, 0);
   endtask

   task automatic single_read(input int x, mean, inv, g, b);
      set_data(x, mean, inv, g, b);
      valid_seen = 0; rd_pulses = 0;
      step(0, 1, 0, 0, 0);
      idle(8);
      check("single_rd_pulses", rd_pulses, 1);
      check("single_valids", valid_seen, 1);
   endtask

   initial begin
      for (int k = 1; k <= 5; k++) rd_h[k] = 1'b0;
      for (int k = 1; k <= 3; k++) in_h[k] = '{0, 0, 0, 0, 0};
      dout_x = 0; cnt_x = 16'd0; fs_x = 1'b0;
      rd_pulses = 0; valid_seen = 0; last_rd_cyc = 0; last_valid_cyc = 0;
      last_dout = 0; last_sat = 1'b0;
      set_data(0, 0, 0, 0, 0);
      rst = 1'b1; bn_en = 1'b0; bn_fifo_empty = 1'b1; out_stall = 1'b0; bn_fifo_full = 1'b0;
      data_in = '0; bn_mean = '0; bn_inv_std = '0; bn_gamma = '0; bn_beta = '0;
      @(posedge clk); #1;

      step(1, 0, 1, 0, 0);
      step(1, 0, 1, 0, 0);
      idle(2);
      check("reset_data_out", data_out, 0);
      check("reset_count", sample_count, 0);

      // nominal sample and its latency
      single_read(512, 256, 128, 512, 64);
      check("nominal_latency", last_valid_cyc - last_rd_cyc, 5);
      check("nominal_value", last_dout, 320);
      check("nominal_sat", last_sat, 0);

      // saturation in both directions
      single_read(32767, -32768, 256, 256, 0);
      check("pos_sat_value", last_dout, 32767);
      check("pos_sat_flag", last_sat, 1);
      single_read(-32768, 32767, 256, 256, 0);
      check("neg_sat_value", last_dout, -32768);
      check("neg_sat_flag", last_sat, 1);

      // streaming: 20 cycles of non-empty FIFO
      step(1, 0, 1, 0, 0);
      rd_pulses = 0; valid_seen = 0;
      for (int i = 0; i < 20; i++) begin rand_data(); step(0, 1, 0, 0, 0); end
      check("stream_rd_pulses", rd_pulses, 10);
      idle(8);
      check("stream_valids", valid_seen, 10);
      check("stream_count", sample_count, 10);

      // stall raised one cycle after a read
      rd_pulses = 0; valid_seen = 0;
      set_data(1000, -200, 300, 700, -50);
      step(0, 1, 0, 0, 0);
      for (int i = 0; i < 4; i++) step(0, 1, 0, 1, 0);
      check("stall_rd_pulses", rd_pulses, 1);
      idle(6);
      check("stall_valids", valid_seen, 1);

      // enable dropped one cycle after a read
      rd_pulses = 0; valid_seen = 0;
      step(0, 1, 0, 0, 0);
      for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0);
      check("en_rd_pulses", rd_pulses, 1);
      idle(6);
      check("en_valids", valid_seen, 1);

      // reset three cycles after a read discards that sample
      valid_seen = 0;
      step(0, 1, 0, 0, 0);
      step(0, 1, 1, 0, 0);
      step(0, 1, 1, 0, 0);
      step(1, 1, 1, 0, 0);
      idle(8);
      check("rst_mid_valids", valid_seen, 0);
      check("rst_mid_count", sample_count, 0);
      check("rst_mid_data_out", data_out, 0);

      // one-cycle full pulse is sticky until reset
      step(0, 1, 1, 0, 1);
      idle(5);
      check("full_sticky", full_seen, 1);
      step(1, 1, 1, 0, 0);
      idle(1);
      check("full_cleared", full_seen, 0);

      // randomized traffic including occasional resets
      for (int i = 0; i < 3000; i++) begin
         rand_data();
         step($urandom_range(0, 99) == 0, $urandom_range(0, 3) != 0,
              $urandom_range(0, 9) < 3, $urandom_range(0, 4) == 0,
              $urandom_range(0, 19) == 0);
      end
      idle(8);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/bn_compute_stage.md
# bn_compute_stage

Batch-normalization compute stage for the CNN feature path. Sits directly downstream of the BN FIFO output register stage. Each sample pops from the BN FIFO through that register stage and computes y = gamma·(x − mean)·inv_std + beta in signed fixed point with saturation. Results stream to the next CNN stage with a valid strobe.

## Interface
- DATA_WIDTH, 16, width of all signed data/parameter words
- FRAC_BITS, 8, fractional bits of the shared Q format (all operands and result)
- READ_LAT, 2, cycles from `rd_en` high to matching `data_in` (FIFO read 1 + register stage 1); legal range 1–4

Ports:
- Reset is `rst`: synchronous, active-high. Clock is `clk`.
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- bn_en  in  1  enable new reads; in-flight samples always complete
- bn_fifo_empty  in  1  registered FIFO empty flag (one cycle stale)
- bn_fifo_full  in  1  registered FIFO full flag (status only)
- out_stall  in  1  downstream back-off; blocks new reads only
- data_in  in  DATA_WIDTH  sample x, valid READ_LAT cycles after `rd_en`
- bn_mean, bn_inv_std, bn_gamma, bn_beta  in  DATA_WIDTH each  per-channel parameters, sampled in the same cycle as `data_in`; `bn_inv_std` is the precomputed 1/sqrt(var+eps)
- rd_en  out  1  FIFO pop pulse
- data_out  out  DATA_WIDTH  normalized sample
- data_valid  out  1  `data_out` valid this cycle
- sat_flag  out  1  sample in `data_out` was clamped (qualified by `data_valid`)
- full_seen  out  1  sticky: `bn_fifo_full` was observed high since reset
- busy  out  1  FSM not IDLE or any sample in flight
- sample_count  out  16  samples emitted since reset; wraps 0xFFFF→0

## Operation
- Read FSM states: IDLE, WAIT.
  - IDLE: if `bn_en & ~bn_fifo_empty & ~out_stall`, assert `rd_en` for one cycle and go to WAIT. Otherwise stay.
  - WAIT: no read; unconditionally return to IDLE.
  - WAIT exists because the empty flag is one cycle stale, so it must never cause a double pop.
  - Maximum throughput is 1 sample per 2 cycles.
- In-flight tracking: shift register of depth READ_LAT fed by `rd_en`. Its tap marks the `data_in` valid cycle (in_valid).
- Pipeline, registered only on in_valid (bubbles propagate as valid=0):
  - S1: diff = data_in − bn_mean, DATA_WIDTH+1 bits. Carry gamma and beta forward.
  - S2: n = (diff·bn_inv_std) >>> FRAC_BITS (arithmetic, truncate toward −inf). Saturate to DATA_WIDTH signed and record sat.
  - S3: y = ((n·gamma) >>> FRAC_BITS) + beta in full width. Saturate to DATA_WIDTH. `sat_flag` = S2 sat | S3 sat.
  - Saturation limits are 2^(W−1)−1 and −2^(W−1).
- `sample_count` increments in each cycle `data_valid` is high.
- `full_seen` sets on any cycle `bn_fifo_full`=1 and clears only on reset.
- Deasserting `bn_en` or raising `out_stall` takes effect from the next IDLE decision. Reads already issued still produce outputs.
- Simultaneous `bn_en` rise and `bn_fifo_empty` fall: a read issues in that same cycle.

## Timing
- Reset values:
  - FSM = IDLE
  - `rd_en`, `data_valid`, `sat_flag`, `full_seen`, `busy` = 0
  - `data_out` = 0, `sample_count` = 0
  - in-flight shift register and all pipeline valids cleared
- Reset mid-operation discards all in-flight samples; no output appears for them.
- Latency: `rd_en` in cycle t gives `data_valid` in cycle t+READ_LAT+3 (default t+5).
- `data_out` holds its last value while `data_valid`=0.
- `rd_en` is never high in two consecutive cycles.

## Test plan
- Nominal, W=16, F=8: x=512, mean=256, inv_std=128, gamma=512, beta=64 -> `data_out`=320 (1.25), `sat_flag`=0, `data_valid` 5 cycles after `rd_en`.
- Positive saturation: x=32767, mean=−32768, inv_std=256, gamma=256, beta=0 -> `data_out`=32767, `sat_flag`=1. Mirror case x=−32768, mean=32767 -> −32768, `sat_flag`=1.
- Streaming: `bn_fifo_empty`=0 for 20 cycles with `bn_en`=1 -> `rd_en` toggles every other cycle (10 pulses), 10 valids, `sample_count`=10.
- Stall/enable: raise `out_stall` one cycle after a read -> no new `rd_en`, the pending sample still emerges. Drop `bn_en` likewise -> in-flight sample still emerges.
- Reset at cycle t+3 after `rd_en` -> no `data_valid` ever for that sample, and every output returns to its reset value.
- `sample_count` preloaded near wrap via 65536 samples -> wraps to 0. A one-cycle `bn_fifo_full` pulse -> `full_seen` stays 1 until `rst`.
